// File: rtl/pipe_sched.sv
// Pipeline stall/flush scheduler: merges hazard, divider and memory-wait requests with exceptions.
// Optional feature: define PIPE_DEBUG_HALT_EN to add the debug_halt freeze port.
module pipe_sched #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned DIV_LAT  = 32
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        stallreq_id,
    input  logic        div_start,
    input  logic        mem_req,
    input  logic        exc_req,
    input  logic [31:0] exc_target,
    input  logic        clr_perf,
`ifdef PIPE_DEBUG_HALT_EN
    input  logic        debug_halt,
`endif
    output logic [4:0]  stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        div_done,
    output logic        mem_ready,
    output logic [31:0] stall_cnt
);

    // state   | meaning
    // RUN     | normal operation, exceptions accepted
    // FLUSH   | pipeline being cleared, stall forced off
    // REFILL  | first fetch from the redirect target
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    localparam logic [5:0] MEM_WAIT_C = 6'(MEM_WAIT);
    localparam logic [5:0] DIV_LAT_C  = 6'(DIV_LAT);

    state_t      state_q, state_d;
    logic [5:0]  mem_cnt_q, mem_cnt_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        div_done_q, div_done_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        exc_take;
    logic        halt;
    logic        mem_busy;
    logic        div_busy;
    logic [4:0]  stall_c;

    always_comb begin
        exc_take = (state_q == ST_RUN) && exc_req;
        mem_busy = (mem_cnt_q != 6'd0);
        div_busy = (div_cnt_q != 6'd0);
`ifdef PIPE_DEBUG_HALT_EN
        halt     = debug_halt && (state_q == ST_RUN) && !exc_req;
`else
        halt     = 1'b0;
`endif
    end

    // Stall priority; requests are gated off while reset is asserted.
    always_comb begin
        stall_c = 5'b00000;
        if (!cpu_rst_n) begin
            stall_c = 5'b00000;
        end else if (exc_take || (state_q == ST_FLUSH)) begin
            stall_c = 5'b00000;
        end else if (halt) begin
            stall_c = 5'b11111;
        end else if (mem_busy || (mem_req && (MEM_WAIT_C != 6'd0))) begin
            stall_c = 5'b01111;
        end else if (div_busy || div_start) begin
            stall_c = 5'b00111;
        end else if (stallreq_id) begin
            stall_c = 5'b00011;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (exc_req) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_REFILL;
            ST_REFILL: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Wait-state and divider latency counters; an accepted exception drops them silently.
    always_comb begin
        mem_cnt_d   = mem_cnt_q;
        mem_ready_d = 1'b0;
        if (exc_take) begin
            mem_cnt_d = 6'd0;
        end else if (!halt) begin
            if (mem_busy) begin
                mem_cnt_d   = mem_cnt_q - 6'd1;
                mem_ready_d = (mem_cnt_q == 6'd1);
            end else if (mem_req) begin
                if (MEM_WAIT_C == 6'd0) begin
                    mem_ready_d = 1'b1;
                end else begin
                    mem_cnt_d = MEM_WAIT_C;
                end
            end
        end
    end

    always_comb begin
        div_cnt_d  = div_cnt_q;
        div_done_d = 1'b0;
        if (exc_take) begin
            div_cnt_d = 6'd0;
        end else if (!halt) begin
            if (div_busy) begin
                div_cnt_d  = div_cnt_q - 6'd1;
                div_done_d = (div_cnt_q == 6'd1);
            end else if (div_start) begin
                div_cnt_d = DIV_LAT_C;
            end
        end
    end

    always_comb begin
        flush_d          = exc_take;
        redirect_valid_d = exc_take;
        redirect_pc_d    = exc_take ? exc_target : redirect_pc_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_perf) begin
            stall_cnt_d = 32'd0;
        end else if ((stall_c != 5'b00000) && !halt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q          <= ST_RUN;
            mem_cnt_q        <= 6'd0;
            div_cnt_q        <= 6'd0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            div_done_q       <= 1'b0;
            mem_ready_q      <= 1'b0;
            stall_cnt_q      <= 32'd0;
        end else begin
            state_q          <= state_d;
            mem_cnt_q        <= mem_cnt_d;
            div_cnt_q        <= div_cnt_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            div_done_q       <= div_done_d;
            mem_ready_q      <= mem_ready_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign stall          = stall_c;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign div_done       = div_done_q;
    assign mem_ready      = mem_ready_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: doc/pipe_sched.md
# pipe_sched

Pipeline stall/flush scheduler for the five-stage MiniMIPS32 core. It merges load-use, divider, and data-memory wait requests with exceptions into one `stall[4:0]` bus, a `flush` pulse and a PC redirect. Every pipeline register (pc, if/id, id/ex, ex/mem, mem/wb) consumes these outputs. It owns the multicycle divider latency counter and the data-memory wait-state counter, and keeps a stall-cycle performance counter.

## Interface
- `MEM_WAIT`, default 2: wait states per data-memory access; range 0..63.
- `DIV_LAT`, default 32: divider latency in cycles; range 1..63.
- `cpu_clk_50M`  in  1  core clock.
- `cpu_rst_n`  in  1  asynchronous active-low reset.
- `stallreq_id`  in  1  load-use hazard from decode.
- `div_start`  in  1  EX stage issues a divide (one-cycle pulse).
- `mem_req`  in  1  MEM stage issues a load/store (one-cycle pulse).
- `exc_req`  in  1  exception or eret committed in MEM.
- `exc_target`  in  32  handler or EPC address.
- `clr_perf`  in  1  synchronous clear of `stall_cnt`.
- `debug_halt`  in  1  freeze request; only present with `PIPE_DEBUG_HALT_EN`.
- `stall`  out  5  bit k = 1 holds register k (0 = pc, 1 = if/id, 2 = id/ex, 3 = ex/mem, 4 = mem/wb).
- `flush`  out  1  clear all pipeline registers; registered.
- `redirect_valid`  out  1  load `redirect_pc` into PC; registered.
- `redirect_pc`  out  32  new fetch address; registered.
- `div_done`  out  1  divider result valid; registered one-cycle pulse.
- `mem_ready`  out  1  memory data valid; registered one-cycle pulse.
- `stall_cnt`  out  32  saturating count of cycles with `stall != 0`.

## Operation
- State machine has three states: RUN, FLUSH, REFILL.
  - RUN with `exc_req`: go to FLUSH.
  - FLUSH: go unconditionally to REFILL.
  - REFILL: go unconditionally to RUN.
- `exc_req` is ignored in FLUSH and REFILL.
- Counters:
  - `mem_cnt`, 6 bits: loaded with `MEM_WAIT` on `mem_req` when it is 0; decrements while nonzero.
  - `div_cnt`, 6 bits: loaded with `DIV_LAT` on `div_start` when it is 0; decrements while nonzero.
  - A start pulse arriving while its counter is nonzero is ignored.
  - `MEM_WAIT` = 0: `mem_ready` pulses the cycle after `mem_req`, with no stall.
- Stall priority, highest first, evaluated combinationally:
  - `exc_req` in RUN, or state FLUSH: stall = 5'b00000.
  - `mem_cnt != 0`, or (`mem_req` and `MEM_WAIT > 0`): stall = 5'b01111.
  - `div_cnt != 0`, or `div_start`: stall = 5'b00111.
  - `stallreq_id`: stall = 5'b00011.
  - Otherwise: stall = 5'b00000.
- A held register keeps its contents. A non-held register whose upstream register is held loads a bubble; this is the register's job.
- Exception handling:
  - On entering FLUSH, both counters clear without generating a done pulse.
  - `redirect_pc` <= `exc_target`.
- Done pulses: `div_done` and `mem_ready` assert for exactly one cycle after the counter steps 1 -> 0.
- `stall_cnt`:
  - Increments when `stall != 0`.
  - Saturates at 32'hFFFF_FFFF.
  - `clr_perf` has priority over increment.

## Timing
- Reset (async, while `cpu_rst_n` = 0) forces:
  - state RUN; `mem_cnt` = 0; `div_cnt` = 0;
  - `flush` = 0, `redirect_valid` = 0, `redirect_pc` = 0, `div_done` = 0, `mem_ready` = 0, `stall_cnt` = 0.
  - `stall` evaluates to 0 because all requests are gated by reset.
- Reset deassertion mid-divide or mid-wait: the counters are already cleared, and no done pulse is produced.
- Exception sampled at edge T: `flush` = 1 and `redirect_valid` = 1 during cycle T..T+1, then both drop to 0.
- Stall latency: zero cycles; the combinational stall is seen by the pipeline registers at the same edge as the request.
- Divide:
  - `div_start` at cycle 0 holds the pipeline for cycles 0..`DIV_LAT`.
  - `div_done` is high in cycle `DIV_LAT`+1.
- Simultaneous `mem_req` and `div_start`: both counters load; the mem pattern wins until `mem_cnt` = 0, then the div pattern applies while `div_cnt` remains nonzero.

## Configuration
- `PIPE_DEBUG_HALT_EN` defined:
  - Adds the `debug_halt` port.
  - While it is high and the state is RUN with no `exc_req`: stall = 5'b11111, and both counters and `stall_cnt` freeze.
  - `exc_req` still overrides it.
- Macro undefined: no port, no halt logic; behaviour is as above with the halt term removed.

## Test plan
- Reset while `div_cnt` = 5: all outputs 0 immediately; after release, no `div_done` appears and stall = 0.
- `stallreq_id` held for 1 cycle: stall = 5'b00011 for exactly that cycle; `stall_cnt` = 1.
- `div_start` with `DIV_LAT` = 32: stall = 5'b00111 for 33 cycles; `div_done` pulses once; a second `div_start` during the busy window is ignored.
- `mem_req` with `MEM_WAIT` = 2 while `div_cnt` = 10: stall = 5'b01111 for 3 cycles, then 5'b00111 until `div_cnt` reaches 0; `mem_ready` pulses once.
- `exc_req` with `exc_target` = 32'hBFC0_0380 during a divide:
  - Next cycle: `flush` = 1, `redirect_valid` = 1, `redirect_pc` = 32'hBFC0_0380, stall = 0.
  - `div_done` never pulses.
  - An `exc_req` during REFILL is ignored.
- `stall_cnt` forced to 32'hFFFF_FFFE with stall active for 3 cycles: counter holds at 32'hFFFF_FFFF; `clr_perf` returns it to 0 the next cycle.
